// File: rtl/frame_buffer_pkg.sv
// Shared sizing helpers and types for the ping-pong frame buffer.
package frame_buffer_pkg;

  localparam int IMG_WIDTH_D  = 30;
  localparam int IMG_HEIGHT_D = 30;
  localparam int IN_W_D       = 8;

  typedef logic [0:0] bank_idx_t;

  function automatic int beats_f(input int bits, input int in_w);
    return (bits + in_w - 1) / in_w;
  endfunction

  function automatic int tail_bits_f(input int bits, input int in_w);
    return bits - (beats_f(bits, in_w) - 1) * in_w;
  endfunction

  // Keeps the beat counter at least 1 bit wide for single-beat frames.
  function automatic int beat_w_f(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/frame_bank.sv
// One frame of pixel storage written one beat at a time; the last beat keeps only its tail bits.
// Latency: write visible on img the cycle after we.
// Backpressure: none, the caller gates we.
module frame_bank
  import frame_buffer_pkg::*;
#(
  parameter int IMG_BITS  = 900,
  parameter int IN_W      = 8,
  parameter int BEATS     = beats_f(IMG_BITS, IN_W),
  parameter int TAIL_BITS = tail_bits_f(IMG_BITS, IN_W),
  parameter int BW        = beat_w_f(BEATS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [BW-1:0]       beat,
  input  logic [IN_W-1:0]     wdat,
  output logic [IMG_BITS-1:0] img
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img <= '0;
    end else if (we) begin
      for (int b = 0; b < BEATS - 1; b++) begin
        if (beat == BW'(b)) img[b*IN_W +: IN_W] <= wdat;
      end
      // Upper bits of the final beat fall outside the image and are dropped.
      if (beat == BW'(BEATS - 1)) img[(BEATS-1)*IN_W +: TAIL_BITS] <= wdat[TAIL_BITS-1:0];
    end
  end

endmodule

// File: rtl/frame_buffer_pp.sv
// Two-bank frame assembler: one bank fills from the beat stream while the other is presented.
// Latency: frame_done/out_valid one cycle after the last beat; release takes effect next cycle.
// Backpressure: in_ready drops while the write bank is still full or clear is high.
module frame_buffer_pp
  import frame_buffer_pkg::*;
#(
  parameter int  IMG_WIDTH  = IMG_WIDTH_D,
  parameter int  IMG_HEIGHT = IMG_HEIGHT_D,
  parameter int  IN_W       = IN_W_D,
  localparam int IMG_BITS   = IMG_WIDTH * IMG_HEIGHT,
  localparam int BEATS      = beats_f(IMG_BITS, IN_W),
  localparam int TAIL_BITS  = tail_bits_f(IMG_BITS, IN_W),
  localparam int BW         = beat_w_f(BEATS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  output logic                clear_done,
  input  logic                in_valid,
  input  logic [IN_W-1:0]     in_data,
  output logic                in_ready,
  output logic                frame_done,
  output logic                out_valid,
  output logic [IMG_BITS-1:0] out_img,
  input  logic                out_ack,
  output logic [1:0]          frames_pending,
  output logic [BW-1:0]       wr_beat,
  output logic                overflow_err
);

  logic [1:0]    full_q, full_d;
  bank_idx_t     wr_bank_q, wr_bank_d;
  bank_idx_t     rd_bank_q, rd_bank_d;
  logic [BW-1:0] wr_beat_q, wr_beat_d;
  logic          ovf_q, ovf_d;
  logic          frame_done_q, frame_done_d;
  logic          clear_done_q;
  logic          wr_fire, wr_last, rd_fire;
  logic [IMG_BITS-1:0] bank_dat [2];

  assign in_ready  = !full_q[wr_bank_q] && !clear;
  assign wr_fire   = in_valid && in_ready;
  assign wr_last   = (wr_beat_q == BW'(BEATS - 1));
  assign out_valid = full_q[rd_bank_q];
  assign rd_fire   = out_ack && out_valid && !clear;

  always_comb begin
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_beat_d    = wr_beat_q;
    frame_done_d = 1'b0;
    ovf_d        = ovf_q | (in_valid && !in_ready);
    if (wr_fire) begin
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_beat_d         = '0;
        frame_done_d      = 1'b1;
      end else begin
        wr_beat_d = wr_beat_q + BW'(1);
      end
    end
    // Completion and release always hit different banks, so both apply.
    if (rd_fire) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (clear) begin
      full_d       = '0;
      wr_bank_d    = '0;
      rd_bank_d    = '0;
      wr_beat_d    = '0;
      frame_done_d = 1'b0;
      ovf_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q       <= '0;
      wr_bank_q    <= '0;
      rd_bank_q    <= '0;
      wr_beat_q    <= '0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_beat_q    <= wr_beat_d;
      ovf_q        <= ovf_d;
      frame_done_q <= frame_done_d;
      clear_done_q <= clear;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    frame_bank #(
      .IMG_BITS  (IMG_BITS),
      .IN_W      (IN_W),
      .BEATS     (BEATS),
      .TAIL_BITS (TAIL_BITS),
      .BW        (BW)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_fire && (wr_bank_q == bank_idx_t'(g))),
      .beat  (wr_beat_q),
      .wdat  (in_data),
      .img   (bank_dat[g])
    );
  end

  assign out_img        = bank_dat[rd_bank_q];
  assign frames_pending = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign wr_beat        = wr_beat_q;
  assign overflow_err   = ovf_q;
  assign frame_done     = frame_done_q;
  assign clear_done     = clear_done_q;

endmodule

// File: tb/tb_frame_buffer_pp.sv
// Scoreboard bench for frame_buffer_pp: default 30x30/8-bit build plus a 28x28/16-bit build.
module tb_frame_buffer_pp;

  localparam int IN_W      = 8;
  localparam int IMG_BITS  = 900;
  localparam int BEATS     = 113;
  localparam int BW        = 7;
  localparam int IN_W2     = 16;
  localparam int IMG_BITS2 = 784;
  localparam int BEATS2    = 49;
  localparam int BW2       = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0, in_valid = 1'b0, out_ack = 1'b0;
  logic [IN_W-1:0] in_data = '0;
  logic clear_done, in_ready, frame_done, out_valid, overflow_err;
  logic [IMG_BITS-1:0] out_img;
  logic [1:0] frames_pending;
  logic [BW-1:0] wr_beat;

  logic clear2 = 1'b0, in_valid2 = 1'b0, out_ack2 = 1'b0;
  logic [IN_W2-1:0] in_data2 = '0;
  logic clear_done2, in_ready2, frame_done2, out_valid2, overflow_err2;
  logic [IMG_BITS2-1:0] out_img2;
  logic [1:0] frames_pending2;
  logic [BW2-1:0] wr_beat2;

  always #5 clk = ~clk;

  frame_buffer_pp dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .clear_done(clear_done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .frame_done(frame_done), .out_valid(out_valid), .out_img(out_img),
    .out_ack(out_ack), .frames_pending(frames_pending), .wr_beat(wr_beat),
    .overflow_err(overflow_err)
  );

  frame_buffer_pp #(.IMG_WIDTH(28), .IMG_HEIGHT(28), .IN_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear2), .clear_done(clear_done2),
    .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .frame_done(frame_done2), .out_valid(out_valid2), .out_img(out_img2),
    .out_ack(out_ack2), .frames_pending(frames_pending2), .wr_beat(wr_beat2),
    .overflow_err(overflow_err2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [IMG_BITS-1:0] exp_q[$];
  logic [IMG_BITS-1:0] pend_frame;
  bit push_pend = 0, exp_fd = 0, exp_cd = 0, ovf_m = 0, chk_en = 0;
  int fd_cnt = 0, fd2_cnt = 0, mon_sz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input logic [IMG_BITS-1:0] act,
                         input logic [IMG_BITS-1:0] exp);
    int bad = -1;
    n_tests++;
    for (int p = IMG_BITS - 1; p >= 0; p--) if (act[p] !== exp[p]) bad = p;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: first bad bit %0d got %b expected %b (low word got %h expected %h)",
               name, bad, act[bad], exp[bad], act[31:0], exp[31:0]);
    end
  endtask

  // Advance one cycle: publish a frame completed on the previous edge, then idle all inputs.
  task automatic tick();
    @(posedge clk); #1;
    exp_fd = push_pend;
    if (push_pend) exp_q.push_back(pend_frame);
    push_pend = 0;
    in_valid = 0; out_ack = 0; clear = 0;
  endtask

  // mode 0: beat k carries k; mode 1: constant k; mode 2: random.
  task automatic send_frame(input int mode, input logic [IN_W-1:0] k, input int nbeats,
                            input bit gaps, input bit ack_last, input bit rand_ack);
    logic [IMG_BITS-1:0] f = '0;
    logic [IN_W-1:0] d;
    int waitc;
    for (int b = 0; b < nbeats; b++) begin
      d = (mode == 0) ? IN_W'(b) : (mode == 1) ? k : IN_W'($urandom);
      for (int i = 0; i < IN_W; i++) if (b * IN_W + i < IMG_BITS) f[b*IN_W+i] = d[i];
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          tick();
          out_ack = rand_ack && ($urandom_range(0, 2) == 0);
          @(negedge clk);
        end
      end
      waitc = 0;
      do begin
        tick();
        in_valid = 1; in_data = d;
        out_ack = (rand_ack && ($urandom_range(0, 2) == 0)) || (ack_last && b == nbeats - 1);
        @(negedge clk);
        waitc++;
      end while (!in_ready && waitc < 300);
      if (!in_ready) begin
        n_tests++; n_fail++;
        $display("FAIL beat_accept: beat %0d not accepted within %0d cycles", b, waitc);
        return;
      end
    end
    if (nbeats == BEATS) begin
      pend_frame = f;
      push_pend = 1;
    end
  endtask

  // Monitor: compares DUT outputs against the frame queue model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      mon_sz = exp_q.size();
      chk("frames_pending", frames_pending, mon_sz);
      chk("out_valid", out_valid, mon_sz > 0);
      chk("in_ready", in_ready, (mon_sz < 2) && !clear);
      chk("frame_done", frame_done, exp_fd);
      chk("clear_done", clear_done, exp_cd);
      chk("overflow_err", overflow_err, ovf_m);
      fd_cnt += int'(frame_done);
      ovf_m = !clear && (ovf_m || (in_valid && mon_sz == 2));
      exp_cd = clear;
      if (out_valid && out_ack && mon_sz > 0) begin
        chk_img("out_img", out_img, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (clear) exp_q.delete();
    end
  end

  always @(negedge clk) fd2_cnt += int'(frame_done2);

  initial begin
    #500000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [IMG_BITS2-1:0] exp2;
    logic [15:0] pat;
    int fd0, waitc;

    #12;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst clear_done", clear_done, 0);
    chk("rst frames_pending", frames_pending, 0);
    chk("rst wr_beat", wr_beat, 0);
    chk("rst overflow_err", overflow_err, 0);
    chk_img("rst out_img", out_img, '0);
    @(negedge clk);
    rst_n = 1;
    chk_en = 1;

    // Single counting frame.
    send_frame(0, '0, BEATS, 0, 0, 0);
    tick(); @(negedge clk);
    chk("t1 frame_done", frame_done, 1);
    chk("t1 out_valid", out_valid, 1);
    chk("t1 byte0", out_img[7:0], 8'h00);
    chk("t1 byte1", out_img[15:8], 8'h01);
    chk("t1 tail", out_img[899:896], 4'h0);
    chk("t1 pending", frames_pending, 1);
    tick(); out_ack = 1; @(negedge clk);
    tick(); @(negedge clk);

    // Both banks full, then an overflowing beat, then one release.
    send_frame(1, 8'hFF, BEATS, 0, 0, 0);
    send_frame(1, 8'h00, BEATS, 0, 0, 0);
    tick(); @(negedge clk);
    chk("stall in_ready", in_ready, 0);
    chk("stall pending", frames_pending, 2);
    tick(); in_valid = 1; in_data = 8'h5A; @(negedge clk);
    tick(); @(negedge clk);
    chk("stall overflow", overflow_err, 1);
    chk("stall wr_beat", wr_beat, 0);
    tick(); out_ack = 1; @(negedge clk);
    tick(); @(negedge clk);
    chk_img("stall frame2", out_img, '0);
    chk("stall in_ready after ack", in_ready, 1);
    tick(); out_ack = 1; @(negedge clk);

    // Last beat of B coincides with the release of A.
    send_frame(2, '0, BEATS, 0, 0, 0);
    send_frame(2, '0, BEATS, 0, 1, 0);
    tick(); @(negedge clk);
    chk("conc frame_done", frame_done, 1);
    chk("conc pending", frames_pending, 1);
    if (exp_q.size() > 0) chk_img("conc out_img", out_img, exp_q[0]);
    tick(); out_ack = 1; @(negedge clk);

    // Mid-frame clear.
    send_frame(2, '0, 50, 0, 0, 0);
    tick(); clear = 1; @(negedge clk);
    chk("clear partial wr_beat", wr_beat, 50);
    chk("clear in_ready", in_ready, 0);
    tick(); @(negedge clk);
    chk("clear_done", clear_done, 1);
    chk("clear wr_beat", wr_beat, 0);
    chk("clear overflow", overflow_err, 0);
    fd0 = fd_cnt;
    send_frame(2, '0, BEATS, 0, 0, 0);
    tick(); @(negedge clk);
    tick(); @(negedge clk);
    chk("clear one frame_done", fd_cnt - fd0, 1);
    tick(); out_ack = 1; @(negedge clk);

    // Random frames with gaps and random releases.
    for (int n = 0; n < 6; n++) send_frame(2, '0, BEATS, 1, 0, 1);
    waitc = 0;
    while ((exp_q.size() > 0 || push_pend) && waitc < 50) begin
      tick(); out_ack = 1; @(negedge clk);
      waitc++;
    end
    chk("drain empty", exp_q.size(), 0);

    // Asynchronous reset with both banks full.
    send_frame(1, 8'h3C, BEATS, 0, 0, 0);
    send_frame(1, 8'hC3, BEATS, 0, 0, 0);
    chk_en = 0;
    @(posedge clk); #2;
    chk("pre-rst pending", frames_pending, 2);
    chk("pre-rst frame_done", frame_done, 1);
    rst_n = 0; #1;
    chk("arst in_ready", in_ready, 1);
    chk("arst out_valid", out_valid, 0);
    chk("arst frame_done", frame_done, 0);
    chk("arst clear_done", clear_done, 0);
    chk("arst pending", frames_pending, 0);
    chk("arst wr_beat", wr_beat, 0);
    chk("arst overflow", overflow_err, 0);
    chk_img("arst out_img", out_img, '0);
    push_pend = 0; exp_q.delete(); ovf_m = 0; exp_fd = 0; exp_cd = 0;
    in_valid = 0; out_ack = 0; clear = 0;
    @(negedge clk);
    rst_n = 1;
    chk_en = 1;

    // 28x28 image in 16-bit beats.
    pat = 16'hA5A5;
    for (int p = 0; p < IMG_BITS2; p++) exp2[p] = pat[p % 16];
    fd0 = fd2_cnt;
    for (int b = 0; b < BEATS2; b++) begin
      @(posedge clk); #1;
      in_valid2 = 1; in_data2 = 16'hA5A5;
    end
    @(posedge clk); #1;
    in_valid2 = 0;
    @(negedge clk);
    chk("p2 out_valid", out_valid2, 1);
    chk("p2 frame_done", frame_done2, 1);
    chk("p2 pending", frames_pending2, 1);
    chk_img("p2 out_img", IMG_BITS'(out_img2), IMG_BITS'(exp2));
    @(posedge clk); #1;
    @(negedge clk);
    chk("p2 one frame_done", fd2_cnt - fd0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_buffer_pp.md
# frame_buffer_pp

Parametrised ping-pong frame buffer that assembles a binary image of IMG_WIDTH × IMG_HEIGHT pixels from IN_W-bit input beats. It holds two complete frames, so the SPI/UART receive path can fill one bank while the BNN inference core reads the other. It replaces the single-bank image buffer:
- Edge-detected writes become a valid/ready handshake.
- A frame-done pulse and an explicit consumer release are added.

## Interface
- IMG_WIDTH, 30, pixels per row
- IMG_HEIGHT, 30, rows per frame
- IN_W, 8, bits per input beat (1..32)
- IMG_BITS, IMG_WIDTH*IMG_HEIGHT, derived; do not override
- BEATS, ceil(IMG_BITS/IN_W), derived; 113 at defaults
- TAIL_BITS, IMG_BITS-(BEATS-1)*IN_W, derived; 4 at defaults
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous abort/flush of both banks
- clear_done  out  1  one-cycle pulse, the cycle after clear is sampled
- in_valid  in  1  input beat valid
- in_data  in  IN_W  input beat, pixel i of the beat at bit i
- in_ready  out  1  buffer can accept a beat this cycle
- frame_done  out  1  one-cycle pulse when the last beat of a frame is accepted
- out_valid  out  1  a complete frame is presented on out_img
- out_img  out  IMG_BITS  frame of the current read bank, pixel p at bit p
- out_ack  in  1  consumer releases the presented frame
- frames_pending  out  2  number of full banks (0..2)
- wr_beat  out  $clog2(BEATS)  beat index within the frame being filled
- overflow_err  out  1  sticky: in_valid was high while in_ready was low; cleared by clear or reset

## Operation
- **State:** bank0/bank1 data, full[1:0], wr_bank, rd_bank, wr_beat, overflow_err.
- **Write acceptance:** a beat is accepted on a cycle with in_valid && in_ready.
- **in_ready:** in_ready = !full[wr_bank] && !clear. It is combinational from registers and clear only; it never depends on in_valid.
- **Normal beat:** an accepted beat with wr_beat < BEATS-1 writes in_data to bank[wr_bank][wr_beat*IN_W +: IN_W]. wr_beat then increments.
- **Last beat:** an accepted beat with wr_beat == BEATS-1 writes only in_data[TAIL_BITS-1:0]; the upper bits are discarded. On the next edge:
  - full[wr_bank] is set;
  - wr_bank toggles;
  - wr_beat returns to 0;
  - frame_done pulses.
- **Read side:** out_valid = full[rd_bank] and out_img = bank[rd_bank], both registered-state driven.
- **Release:** out_ack while out_valid clears full[rd_bank] and toggles rd_bank on the next edge. out_ack while !out_valid is ignored.
- **Simultaneous last beat and ack:** these always target different banks. Both take effect in the same cycle, and frames_pending stays unchanged.
- **Both banks full:** in_ready=0 and writes stall. Beats offered while stalled are not written and set overflow_err.
- **clear:** takes priority over everything else. On the next edge:
  - full, wr_bank, rd_bank, wr_beat and overflow_err go to 0;
  - clear_done pulses.

  Bank data is retained but is not valid. A partially written frame is discarded.
- **Reset:** full=0, wr_bank=0, rd_bank=0, wr_beat=0, overflow_err=0. Resulting outputs: in_ready=1, out_valid=0, frame_done=0, clear_done=0, frames_pending=0. Bank contents are zeroed, so out_img=0.
- **frames_pending:** full[0]+full[1], 2 bits, no overflow possible.

## Timing
- Throughput is one beat per cycle while in_ready=1. Minimum frame fill time is BEATS cycles.
- Latency from final beat acceptance to frame_done and out_valid is 1 cycle. Both assert on the same cycle.
- Release latency: after out_ack is sampled, out_valid drops or switches to the other bank's frame on the next cycle. A consumer holding out_ack for 2 cycles therefore releases 2 frames if both are full.
- in_ready rises the cycle after the out_ack that frees a stalled write bank.
- clear sampled on cycle N: in_ready=0 on N (combinational), clear_done=1 on N+1, in_ready=1 on N+1.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is lost.

## Structure
- **Package frame_buffer_pkg:**
  - constant functions beats_f(bits, in_w) and tail_bits_f(bits, in_w);
  - a bank index typedef (1 bit);
  - defaults IMG_WIDTH_D=30, IMG_HEIGHT_D=30, IN_W_D=8.
- **Sub-module frame_bank:** one IMG_BITS storage register with a beat-indexed write port and tail masking. It is instantiated twice.
- **Top level:** pointers, full flags, handshake, pulses and error flag. Expected size is about 200–300 lines of RTL.

## Test plan
- **Single frame, defaults:** after reset, stream 113 beats, with beat k = k[7:0], no gaps.
  - frame_done and out_valid rise 1 cycle after beat 112.
  - out_img[7:0]=0x00, out_img[15:8]=0x01, out_img[899:896]=0x0 (low 4 bits of 0x70).
  - frames_pending=1.
- **Ping-pong stall:** fill 2 frames (all 0xFF, then all 0x00) with no ack.
  - in_ready=0 and frames_pending=2.
  - Offer one more beat: overflow_err=1 and nothing is written.
  - Pulse out_ack for 1 cycle: out_img=0 (frame 2), in_ready=1.
- **Concurrent completion and release:** with frame A presented, complete frame B's last beat in the same cycle as out_ack.
  - frame_done=1, frames_pending stays 1, out_img shows frame B.
- **Mid-frame clear:** after 50 beats, assert clear for 1 cycle.
  - clear_done pulses, wr_beat=0, overflow_err=0.
  - A fresh 113-beat frame then produces exactly one frame_done.
- **Reset mid-operation:** deassert rst_n with frames_pending=2.
  - All outputs return to reset values asynchronously.
- **Parametrised build:** IMG_WIDTH=IMG_HEIGHT=28, IN_W=16 (BEATS=49, TAIL_BITS=16).
  - Stream 49 beats of 0xA5A5: out_img = 784 bits of the 0xA5A5 pattern; frame_done occurs once.
